// File: rtl/ssp_uart_host_bridge_pkg.sv
// Shared types for the ssp_uart host bridge.
// Request bundle and FSM state encoding.
package ssp_host_pkg;

  localparam int SSP_ADDR_W = 3;
  localparam int SSP_DATA_W = 12;
  localparam logic [SSP_ADDR_W-1:0] UCR_ADDR = 3'h0;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP
  } ssp_host_state_e;

  typedef struct packed {
    logic [SSP_ADDR_W-1:0] addr;
    logic                  wnr;
    logic [SSP_DATA_W-1:0] wdata;
  } ssp_host_req_t;

endpackage

// File: rtl/ssp_uart_host_bridge_if.sv
// Host request/response port plus SSP slave pins.
// master = upstream host side, slave = bridge side.
interface ssp_uart_host_bridge_if;
  import ssp_host_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [SSP_ADDR_W-1:0] req_addr;
  logic                  req_wnr;
  logic [SSP_DATA_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [SSP_ADDR_W-1:0] rsp_addr;
  logic [SSP_DATA_W-1:0] rsp_rdata;

  logic                  SSP_SSEL;
  logic [SSP_ADDR_W-1:0] SSP_RA;
  logic                  SSP_WnR;
  logic [SSP_DATA_W-1:0] SSP_DI;
  logic                  SSP_EOC;
  logic [SSP_DATA_W-1:0] SSP_DO;

  modport master (
    output req_valid, req_addr, req_wnr, req_wdata, rsp_ready,
    output SSP_DO,
    input  req_ready, rsp_valid, rsp_addr, rsp_rdata,
    input  SSP_SSEL, SSP_RA, SSP_WnR, SSP_DI, SSP_EOC
  );

  modport slave (
    input  req_valid, req_addr, req_wnr, req_wdata, rsp_ready,
    input  SSP_DO,
    output req_ready, rsp_valid, rsp_addr, rsp_rdata,
    output SSP_SSEL, SSP_RA, SSP_WnR, SSP_DI, SSP_EOC
  );

endinterface

// File: rtl/ssp_uart_host_bridge_fifo.sv
// Request FIFO for the ssp_uart host bridge.
// Power-of-2 depth, pointers wrap naturally.
module ssp_host_req_fifo
  import ssp_host_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  ssp_host_req_t i_data,
  input  logic          i_pop,
  output ssp_host_req_t o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  ssp_host_req_t r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_full;
  logic [AW:0]   w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + (AW+1)'(i_push)
                   - (AW+1)'(i_pop);

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_full  = r_full;
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/ssp_uart_host_bridge.sv
// Host-to-SSP master for ssp_uart: queues register
// requests and serialises each into one SSP frame.
module ssp_uart_host_bridge
  import ssp_host_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_CYCLES = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic Clk,
  input  logic Rst,
  ssp_uart_host_bridge_if.slave bus,
  output logic busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(FRAME_CYCLES - 2);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  ssp_host_state_e       r_state;
  logic [CW-1:0]         r_cnt;
  logic [GW-1:0]         r_gcnt;
  logic                  r_rdy;
  logic                  r_ssel;
  logic                  r_eoc;
  logic [SSP_ADDR_W-1:0] r_ra;
  logic                  r_wnr;
  logic [SSP_DATA_W-1:0] r_di;
  logic                  r_rsp_valid;
  logic [SSP_ADDR_W-1:0] r_rsp_addr;
  logic [SSP_DATA_W-1:0] r_rsp_rdata;

  ssp_host_req_t w_req;
  ssp_host_req_t w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;

  assign w_req = '{addr:  bus.req_addr,
                   wnr:   bus.req_wnr,
                   wdata: bus.req_wdata};

  assign bus.req_ready = r_rdy & ~w_full;
  assign w_push = bus.req_valid & bus.req_ready;
  // A pending response blocks every new frame, reads and writes alike.
  assign w_pop  = (r_state == IDLE) & ~w_empty & ~r_rsp_valid;

  ssp_host_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_rdy       <= 1'b0;
      r_ssel      <= 1'b0;
      r_eoc       <= 1'b0;
      r_ra        <= '0;
      r_wnr       <= 1'b0;
      r_di        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (r_rsp_valid && bus.rsp_ready) r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= FRAME;
            r_cnt   <= '0;
            r_ssel  <= 1'b1;
            r_ra    <= w_head.addr;
            r_wnr   <= w_head.wnr;
            r_di    <= w_head.wnr ? w_head.wdata : '0;
          end
        end
        FRAME: begin
          r_cnt <= r_cnt + 1'b1;
          // EOC is registered, so it is set one cycle ahead.
          r_eoc <= (r_cnt == PRE);
          if (r_cnt == LAST) begin
            r_state <= GAP;
            r_gcnt  <= '0;
            r_ssel  <= 1'b0;
            r_eoc   <= 1'b0;
            r_ra    <= '0;
            r_wnr   <= 1'b0;
            r_di    <= '0;
            if (!r_wnr) begin
              r_rsp_valid <= 1'b1;
              r_rsp_addr  <= r_ra;
              r_rsp_rdata <= bus.SSP_DO;
            end
          end
        end
        GAP: begin
          r_gcnt <= r_gcnt + 1'b1;
          if (r_gcnt == GLAST) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.SSP_SSEL  = r_ssel;
  assign bus.SSP_EOC   = r_eoc;
  assign bus.SSP_RA    = r_ra;
  assign bus.SSP_WnR   = r_wnr;
  assign bus.SSP_DI    = r_di;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_addr  = r_rsp_addr;
  assign bus.rsp_rdata = r_rsp_rdata;

  assign busy = (r_state != IDLE) | (w_count != '0)
              | r_rsp_valid;

endmodule

// File: tb/tb_ssp_uart_host_bridge.sv
// Scoreboard bench for ssp_uart_host_bridge with a
// small ssp_uart register-file slave model.
module tb_ssp_uart_host_bridge;
  import ssp_host_pkg::*;

  localparam int FC = 16;
  localparam int GC = 2;
  localparam int DEPTH = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic busy;

  ssp_uart_host_bridge_if bus ();

  ssp_uart_host_bridge #(
    .FIFO_DEPTH   (DEPTH),
    .FRAME_CYCLES (FC),
    .GAP_CYCLES   (GC)
  ) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]  ra;
    logic        wnr;
    logic [11:0] di;
  } frm_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [11:0] data;
  } rsp_t;

  int total = 0;
  int bad = 0;
  frm_t exp_q[$];
  rsp_t rsp_q[$];
  logic [11:0] regs [8];
  logic [11:0] exp_regs [8];
  logic a5a_mode = 1'b0;
  logic [11:0] garbage = 12'h0;
  int frames_started = 0;
  int frames_done = 0;

  // slave model
  always @(posedge Clk)
    if (bus.SSP_SSEL && bus.SSP_EOC && bus.SSP_WnR)
      regs[bus.SSP_RA] <= bus.SSP_DI;

  always @(negedge Clk) garbage <= 12'($urandom);

  assign bus.SSP_DO = bus.SSP_EOC
                    ? (a5a_mode ? 12'hA5A : regs[bus.SSP_RA])
                    : garbage;

  // frame monitor
  frm_t cur, ef, now_f;
  int len, eoc_n, eoc_at, gap;
  logic stable_ok;
  logic in_frame = 1'b0;
  logic had_frame = 1'b0;

  always @(negedge Clk) begin
    now_f = {bus.SSP_RA, bus.SSP_WnR, bus.SSP_DI};
    if (!Rst) begin
      in_frame = 1'b0;
      had_frame = 1'b0;
      gap = 0;
    end else if (bus.SSP_SSEL) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        frames_started++;
        cur = now_f;
        len = 0;
        eoc_n = 0;
        eoc_at = 0;
        stable_ok = 1'b1;
        if (had_frame) begin
          total++;
          if (gap < GC + 1) begin
            bad++;
            $display("FAIL gap: got %0d need >=%0d", gap, GC + 1);
          end
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected: got %h need none", cur);
        end else begin
          ef = exp_q.pop_front();
          if (cur !== ef) begin
            bad++;
            $display("FAIL frame_fields: got %h need %h", cur, ef);
          end
        end
      end
      len++;
      if (now_f !== cur) stable_ok = 1'b0;
      if (bus.SSP_EOC) begin
        eoc_n++;
        eoc_at = len;
      end
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        had_frame = 1'b1;
        gap = 1;
        frames_done++;
        total++;
        if (len != FC || eoc_n != 1 || eoc_at != FC || !stable_ok) begin
          bad++;
          $display("FAIL frame_shape: got len=%0d eoc=%0d@%0d stable=%0b need len=%0d eoc=1@%0d stable=1",
                   len, eoc_n, eoc_at, stable_ok, FC, FC);
        end
        total++;
        if (bus.rsp_valid !== !cur.wnr) begin
          bad++;
          $display("FAIL rsp_timing: got %b need %b", bus.rsp_valid, !cur.wnr);
        end
      end else begin
        gap++;
      end
    end
  end

  // response monitor
  rsp_t rh, er;
  logic seen = 1'b0;

  always @(negedge Clk) begin
    if (!Rst) begin
      seen = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        rh = {bus.rsp_addr, bus.rsp_rdata};
        total++;
        if (rsp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got %h need none", rh);
        end else begin
          er = rsp_q.pop_front();
          if (rh !== er) begin
            bad++;
            $display("FAIL rsp_data: got %h need %h", rh, er);
          end
        end
      end
      if (bus.rsp_ready) begin
        total++;
        if ({bus.rsp_addr, bus.rsp_rdata} !== rh) begin
          bad++;
          $display("FAIL rsp_stable: got %h need %h",
                   {bus.rsp_addr, bus.rsp_rdata}, rh);
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic send(input logic [2:0] a, input logic w,
                      input logic [11:0] d, input logic [11:0] rexp,
                      output int waited);
    exp_q.push_back({a, w, w ? d : 12'h000});
    if (w) exp_regs[a] = d;
    else   rsp_q.push_back({a, rexp});
    waited = 0;
    @(negedge Clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wnr   = w;
    bus.req_wdata = d;
    while (!bus.req_ready && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    @(posedge Clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    int n = 0;
    @(negedge Clk);
    while (busy && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    ok = !busy;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    @(negedge Clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.SSP_SSEL, bus.SSP_EOC,
         bus.SSP_RA, bus.SSP_WnR, bus.SSP_DI, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero need all 0");
    end
    Rst = 1'b1;
    @(negedge Clk);
    total++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b busy=%b need 1 0",
               bus.req_ready, busy);
    end
  endtask

  task automatic test_write_ucr();
    int w;
    int n0;
    logic ok;
    logic s1, s2, e17, s18;
    n0 = frames_done;
    send(UCR_ADDR, 1'b1, 12'hDED, 12'h0, w);
    @(negedge Clk); s1 = bus.SSP_SSEL;
    @(negedge Clk); s2 = bus.SSP_SSEL;
    repeat (FC - 1) @(negedge Clk);
    e17 = bus.SSP_EOC;
    @(negedge Clk); s18 = bus.SSP_SSEL;
    total++;
    if ({s1, s2, e17, s18} !== 4'b0110) begin
      bad++;
      $display("FAIL write_latency: got %b need 0110", {s1, s2, e17, s18});
    end
    wait_idle(ok);
    total++;
    if (!ok || frames_done != n0 + 1 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL write_ucr: got idle=%b frames=%0d rsp=%b need 1 %0d 0",
               ok, frames_done - n0, bus.rsp_valid, 1);
    end
  endtask

  task automatic test_write_read();
    int w;
    int n0;
    logic ok;
    n0 = frames_done;
    send(UCR_ADDR, 1'b1, 12'hDED, 12'h0, w);
    send(UCR_ADDR, 1'b0, 12'h0, 12'hDED, w);
    wait_idle(ok);
    total++;
    if (!ok || frames_done != n0 + 2 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL write_read: got idle=%b frames=%0d pend=%0d need 1 2 0",
               ok, frames_done - n0, rsp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int w [6];
    int n0;
    logic ok;
    logic rdy_after;
    n0 = frames_done;
    for (int i = 0; i < 6; i++) begin
      send(3'(i), 1'b1, 12'h100 + 12'(i), 12'h0, w[i]);
      if (i == 4) rdy_after = bus.req_ready;
    end
    total++;
    if (w[0] + w[1] + w[2] + w[3] + w[4] != 0) begin
      bad++;
      $display("FAIL b2b_accept: got waits %0d %0d %0d %0d %0d need 0",
               w[0], w[1], w[2], w[3], w[4]);
    end
    total++;
    if (rdy_after !== 1'b0) begin
      bad++;
      $display("FAIL b2b_full: got ready=%b need 0", rdy_after);
    end
    total++;
    if (w[5] == 0 || w[5] >= 200) begin
      bad++;
      $display("FAIL b2b_stall: got wait=%0d need 1..199", w[5]);
    end
    wait_idle(ok);
    total++;
    if (!ok || frames_done != n0 + 6) begin
      bad++;
      $display("FAIL b2b_frames: got %0d need 6", frames_done - n0);
    end
  endtask

  task automatic test_rsp_hold();
    int w;
    int n0;
    logic ok;
    n0 = frames_done;
    bus.rsp_ready = 1'b0;
    send(3'd1, 1'b0, 12'h0, exp_regs[1], w);
    send(3'd2, 1'b0, 12'h0, exp_regs[2], w);
    repeat (50) @(negedge Clk);
    total++;
    if (frames_done != n0 + 1 || bus.rsp_valid !== 1'b1 || rsp_q.size() != 1) begin
      bad++;
      $display("FAIL rsp_hold: got frames=%0d valid=%b pend=%0d need 1 1 1",
               frames_done - n0, bus.rsp_valid, rsp_q.size());
    end
    bus.rsp_ready = 1'b1;
    wait_idle(ok);
    total++;
    if (!ok || frames_done != n0 + 2 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL rsp_release: got frames=%0d pend=%0d need 2 0",
               frames_done - n0, rsp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int w;
    int n;
    int n0;
    send(3'd4, 1'b1, 12'h444, 12'h0, w);
    n = 0;
    @(negedge Clk);
    while (!bus.SSP_SSEL && n < 50) begin
      @(negedge Clk);
      n++;
    end
    send(3'd5, 1'b1, 12'h555, 12'h0, w);
    send(3'd6, 1'b1, 12'h666, 12'h0, w);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    #1;
    total++;
    if (bus.SSP_SSEL !== 1'b0 || bus.SSP_EOC !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got ssel=%b eoc=%b need 0 0",
               bus.SSP_SSEL, bus.SSP_EOC);
    end
    exp_q.delete();
    rsp_q.delete();
    n0 = frames_started;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (40) @(negedge Clk);
    total++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1 ||
        frames_started != n0 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_discard: got busy=%b ready=%b frames=%0d rsp=%b need 0 1 0 0",
               busy, bus.req_ready, frames_started - n0, bus.rsp_valid);
    end
  endtask

  task automatic test_do_sampling();
    int w;
    int n0;
    logic ok;
    n0 = frames_done;
    a5a_mode = 1'b1;
    send(3'd3, 1'b0, 12'h0, 12'hA5A, w);
    wait_idle(ok);
    a5a_mode = 1'b0;
    total++;
    if (!ok || frames_done != n0 + 1 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL do_sampling: got frames=%0d pend=%0d need 1 0",
               frames_done - n0, rsp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      regs[i] = 12'h0;
      exp_regs[i] = 12'h0;
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = 3'h0;
    bus.req_wnr   = 1'b0;
    bus.req_wdata = 12'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge Clk);
    test_reset();
    test_write_ucr();
    test_write_read();
    test_back_to_back();
    test_rsp_hold();
    test_reset_midframe();
    test_do_sampling();
    total++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got frames=%0d rsps=%0d need 0 0",
               exp_q.size(), rsp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
